instr_cache: RTL

INSTR_CACHE -- requirements
Module: instr_cache

---
 rtl/cache_pkg.sv | 19 +
 rtl/icache_array.sv | 61 ++++++
 rtl/instr_cache.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the instruction cache: FSM encoding, default geometry,
// and the saturating counter helper.
package cache_pkg;

  localparam int LINES_DEF = 16;
  localparam int WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
// Combinational read; independent word and tag+valid write ports; bulk valid clear.
module icache_array #(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int TAG_W = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(LINES)-1:0] rd_idx,
  input  logic [$clog2(WORDS)-1:0] rd_off,
  output logic                     rd_valid,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [31:0]              rd_word,
  input  logic                     word_we,
  input  logic [$clog2(LINES)-1:0] word_idx,
  input  logic [$clog2(WORDS)-1:0] word_off,
  input  logic [31:0]              word_data,
  input  logic                     tag_we,
  input  logic [$clog2(LINES)-1:0] tag_idx,
  input  logic [TAG_W-1:0]         tag_data,
  input  logic                     clr_all
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][WORDS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_word  = data_mem[rd_idx][rd_off];

  // A clear wins over a same-cycle line install, so a pending invalidate
  // also kills the line that is just being completed.
  always_comb begin
    valid_d = valid_q;
    if (clr_all) begin
      valid_d = '0;
    end else if (tag_we) begin
      valid_d[tag_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (word_we) begin
      data_mem[word_idx][word_off] <= word_data;
    end
    if (tag_we) begin
      tag_mem[tag_idx] <= tag_data;
    end
  end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with zero-latency hits,
// a single outstanding line refill, deferred invalidate and perf counters.
module instr_cache
  import cache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_instr,
  output logic        cpu_stall,
  input  logic        inval,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 32 - IDX_W - OFF_W - 2;
  localparam int LINE_W = 32 - OFF_W - 2;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              unused_addr_bits;

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic              pend_q, pend_d;
  logic [31:0]       hit_q, hit_d;
  logic [31:0]       miss_q, miss_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_word;
  logic              hit;
  logic              word_we, tag_we, clr_all;

  assign req_off = cpu_addr[OFF_W+1:2];
  assign req_idx = cpu_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign req_tag = cpu_addr[31:IDX_W+OFF_W+2];
  // Byte-lane bits carry no information for word fetches.
  assign unused_addr_bits = ^cpu_addr[1:0];

  icache_array #(
    .LINES(LINES),
    .WORDS(WORDS),
    .TAG_W(TAG_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (req_idx),
    .rd_off   (req_off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_word  (rd_word),
    .word_we  (word_we),
    .word_idx (line_q[IDX_W-1:0]),
    .word_off (beat_q),
    .word_data(mem_resp_data),
    .tag_we   (tag_we),
    .tag_idx  (line_q[IDX_W-1:0]),
    .tag_data (line_q[LINE_W-1:IDX_W]),
    .clr_all  (clr_all)
  );

  assign hit          = rd_valid && (rd_tag == req_tag);
  assign cpu_instr    = rd_word;
  assign mem_req_addr = {line_q, {(OFF_W + 2){1'b0}}};
  assign hit_count    = hit_q;
  assign miss_count   = miss_q;

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    pend_d        = pend_q;
    hit_d         = hit_q;
    miss_d        = miss_q;
    line_d        = line_q;
    cpu_stall     = 1'b1;
    mem_req_valid = 1'b0;
    word_we       = 1'b0;
    tag_we        = 1'b0;
    clr_all       = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_stall = cpu_req && !hit;
        clr_all   = inval;
        if (cpu_req) begin
          if (hit) begin
            hit_d = sat_inc(hit_q);
          end else begin
            miss_d  = sat_inc(miss_q);
            line_d  = cpu_addr[31:OFF_W+2];
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        pend_d        = pend_q || inval;
        if (mem_req_ready) begin
          state_d = FILL;
        end
      end
      FILL: begin
        pend_d = pend_q || inval;
        if (mem_resp_valid) begin
          word_we = 1'b1;
          if (beat_q == OFF_W'(WORDS - 1)) begin
            tag_we  = 1'b1;
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + OFF_W'(1);
          end
        end
      end
      DONE: begin
        // An invalidate arriving in this very cycle still has to take effect.
        clr_all = pend_q || inval;
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      pend_q  <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      pend_q  <= pend_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

endmodule
